// File: rtl/handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : handshake_rr_arbiter
// Description : Round-robin arbiter with burst locking. It shares one
//               valid/ready datapath between NUM_SRC sources. A beat moves
//               through a single output register, and each beat carries the
//               index of the source that produced it.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_rr_arbiter #(
    parameter  int WIDTH     = 9,
    parameter  int NUM_SRC   = 4,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     s_rst,
    input  logic [NUM_SRC-1:0]       src_vaild,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic                     dst_vaild,
    output logic [WIDTH-1:0]         dst_data,
    output logic [ID_W-1:0]          dst_src_id,
    input  logic                     dst_ready,
    output logic [NUM_SRC-1:0]       grant,
    output logic                     idle
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]      c_S_IDLE      = 1'b0;
    localparam logic [0:0]      c_S_GRANT     = 1'b1;
    // A burst ends on the handshake whose count reaches MAX_BURST-1.
    localparam logic [7:0]      c_BURST_LAST  = 8'(MAX_BURST - 1);
    // Setting the reset value to the last index makes source 0 win the first arbitration.
    localparam logic [ID_W-1:0] c_LAST_ID_RST = ID_W'(NUM_SRC - 1);

    // ------------------------------------------------------------------------
    // Round-robin pick. The scan starts at (last+1) mod NUM_SRC and wraps.
    // The loop runs from farthest to nearest, so the nearest requester
    // overwrites the others. The MSB of the result means "found".
    // ------------------------------------------------------------------------
    function automatic logic [ID_W:0] f_rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [ID_W-1:0]    last
    );
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx_t;
        int              idx;
        res = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx   = (int'(last) + k) % NUM_SRC;
            idx_t = idx[ID_W-1:0];
            if (req[idx_t]) begin
                res = {1'b1, idx_t};
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [NUM_SRC-1:0] r_grant;
    logic [ID_W-1:0]    r_cur_id;
    logic [ID_W-1:0]    r_last_id;
    logic [7:0]         r_burst_cnt;
    logic               r_dst_vaild;
    logic [WIDTH-1:0]   r_dst_data;
    logic [ID_W-1:0]    r_dst_src_id;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [0:0]         w_state_nxt;
    logic [NUM_SRC-1:0] w_src_ready;
    logic               w_can_accept;
    logic [ID_W:0]      w_pick;
    logic               w_pick_found;
    logic [ID_W-1:0]    w_pick_id;
    logic [NUM_SRC-1:0] w_pick_onehot;
    logic               w_cur_vaild;
    logic               w_load;
    logic               w_burst_end;
    logic               w_grant_end;
    logic [WIDTH-1:0]   w_src_data_arr [NUM_SRC];
    logic [WIDTH-1:0]   w_sel_data;

    // Split the packed source bus into one entry per source.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_data_arr[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register can take a new beat when it is empty or is draining this cycle.
    assign w_can_accept = !r_dst_vaild || dst_ready;

    assign w_pick       = f_rr_pick(src_vaild, r_last_id);
    assign w_pick_found = w_pick[ID_W];
    assign w_pick_id    = w_pick[ID_W-1:0];

    assign w_cur_vaild  = src_vaild[r_cur_id];
    assign w_sel_data   = w_src_data_arr[r_cur_id];

    // A source beat is accepted only from the granted source.
    assign w_load       = w_src_ready[r_cur_id] && w_cur_vaild;
    // Stall cycles do not advance the counter, so only real handshakes end a burst.
    assign w_burst_end  = w_load && (r_burst_cnt == c_BURST_LAST);
    assign w_grant_end  = w_burst_end || !w_cur_vaild;

    // Convert the picked index to a one-hot vector for the grant register.
    always_comb begin
        w_pick_onehot            = '0;
        w_pick_onehot[w_pick_id] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // IDLE opens a grant when anyone requests. GRANT closes on burst end or source drop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = c_S_GRANT;
                end
            end
            c_S_GRANT: begin
                if (w_grant_end) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // Only the granted source sees ready, and only while the output register can accept.
    always_comb begin
        w_src_ready = '0;
        if (r_state == c_S_GRANT) begin
            w_src_ready[r_cur_id] = w_can_accept;
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration bookkeeping: grant vector, current/last id, burst counter
    // ------------------------------------------------------------------------
    // Latch the winner on entering GRANT. Record it as last served on leaving GRANT.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_grant     <= '0;
            r_cur_id    <= '0;
            r_last_id   <= c_LAST_ID_RST;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_pick_found) begin
                        r_grant     <= w_pick_onehot;
                        r_cur_id    <= w_pick_id;
                        r_burst_cnt <= '0;
                    end
                end
                c_S_GRANT: begin
                    if (w_grant_end) begin
                        r_grant     <= '0;
                        r_last_id   <= r_cur_id;
                        r_burst_cnt <= '0;
                    end else if (w_load) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end
                default: begin
                    r_grant     <= '0;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------------
    // Load on a source handshake, otherwise drain on a destination handshake.
    // Data and id change only on a load.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_dst_vaild  <= 1'b0;
            r_dst_data   <= '0;
            r_dst_src_id <= '0;
        end else if (w_load) begin
            r_dst_vaild  <= 1'b1;
            r_dst_data   <= w_sel_data;
            r_dst_src_id <= r_cur_id;
        end else if (dst_ready) begin
            r_dst_vaild  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Port assignments
    // ------------------------------------------------------------------------
    assign src_ready  = w_src_ready;
    assign dst_vaild  = r_dst_vaild;
    assign dst_data   = r_dst_data;
    assign dst_src_id = r_dst_src_id;
    assign grant      = r_grant;
    assign idle       = (r_state == c_S_IDLE) && !r_dst_vaild;

endmodule
`default_nettype wire

// File: tb/tb_handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_rr_arbiter
// Description : Self-checking bench for handshake_rr_arbiter. It runs
//               directed scenarios first, then a randomized soak that is
//               scored per source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_rr_arbiter;

    logic        clk;
    logic        s_rst;
    logic [3:0]  src_vaild;
    logic [35:0] src_data;
    logic [3:0]  src_ready;
    logic        dst_vaild;
    logic [8:0]  dst_data;
    logic [1:0]  dst_src_id;
    logic        dst_ready;
    logic [3:0]  grant;
    logic        idle;

    handshake_rr_arbiter #(
        .WIDTH     (9),
        .NUM_SRC   (4),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .s_rst      (s_rst),
        .src_vaild  (src_vaild),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .dst_vaild  (dst_vaild),
        .dst_data   (dst_data),
        .dst_src_id (dst_src_id),
        .dst_ready  (dst_ready),
        .grant      (grant),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    // Directed-source model: next data word and beats still to send.
    logic [8:0]  dval [4];
    int          rem  [4];

    // Soak scoreboard
    int          sent [4];
    int          recv [4];
    int          wt   [4];

    // Test 1 expectations, one entry per sample cycle
    int          ev1 [9] = '{0, 0, 1, 1, 1, 1, 0, 1, 0};
    int          er1 [7] = '{0, 1, 1, 1, 1, 0, 1};
    logic        rv1 [9];
    logic        rr1 [9];
    logic [8:0]  rd1 [9];
    logic [1:0]  ri1 [9];

    // Test 4 expectations
    logic [3:0]  eg4 [5] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    int          ei4 [7] = '{1, 1, 3, 3, 3, 3, 0};
    logic [3:0]  gq [$];
    int          iq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            src_data[i*9 +: 9] = dval[i];
            src_vaild[i]       = (rem[i] > 0);
        end
    endtask

    // One clock of the directed-source model. A source advances after each accepted beat.
    task automatic run_cycle();
        logic [3:0] hs;
        hs = src_vaild & src_ready;
        chk("src_ready_onehot", 32'($countones(src_ready) <= 1), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                dval[i] = dval[i] + 9'd1;
                if (rem[i] > 0) rem[i]--;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        s_rst     = 1'b1;
        dst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            dval[i] = {2'(i), 7'd0};
        end
        drive();
        run_cycle();
        run_cycle();
        s_rst = 1'b0;
    endtask

    // One soak clock: random sources that hold each beat until it is accepted, plus per-source scoring.
    task automatic soak_cycle(input bit allow_new, input bit rand_ready);
        logic [3:0] hs;
        logic       stall;
        int         id;
        dst_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
        #1;
        hs    = src_vaild & src_ready;
        stall = (grant != 4'b0) && dst_vaild && !dst_ready;
        chk("soak_onehot", 32'($countones(src_ready) <= 1), 1);
        if (dst_vaild && dst_ready) begin
            id = int'(dst_src_id);
            chk("soak_data", 32'(dst_data), 32'({dst_src_id, 7'(recv[id])}));
            recv[id]++;
        end
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                chk("soak_fair", 32'(wt[i] <= 20), 1);
                wt[i] = 0;
            end else if (src_vaild[i] && !stall) begin
                wt[i]++;
            end else if (!src_vaild[i]) begin
                wt[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) sent[i]++;
            if (src_vaild[i] && !hs[i]) src_vaild[i] = 1'b1;
            else                        src_vaild[i] = allow_new && ($urandom_range(0, 1) == 1);
            src_data[i*9 +: 9] = {2'(i), 7'(sent[i])};
        end
    endtask

    initial begin
        int         k;
        int         beats;
        int         n;
        int         bcyc [$];
        int         bid  [$];
        logic [8:0] bdat [$];
        logic [3:0] prev;
        bit         stall_done;
        bit         found;

        s_rst     = 1'b1;
        dst_ready = 1'b1;
        src_vaild = '0;
        src_data  = '0;

        // ---------------- Test 1: reset state, then a single source sending 5 beats
        do_reset();
        chk("rst_idle",       32'(idle),       1);
        chk("rst_grant",      32'(grant),      0);
        chk("rst_src_ready",  32'(src_ready),  0);
        chk("rst_dst_vaild",  32'(dst_vaild),  0);
        chk("rst_dst_data",   32'(dst_data),   0);
        chk("rst_dst_src_id", 32'(dst_src_id), 0);

        rem[0]  = 5;
        dval[0] = 9'h011;
        drive();
        #1;
        for (int c = 0; c < 9; c++) begin
            rv1[c] = dst_vaild;
            rr1[c] = src_ready[0];
            rd1[c] = dst_data;
            ri1[c] = dst_src_id;
            run_cycle();
        end
        k = 0;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("t1_vaild_c%0d", c), 32'(rv1[c]), 32'(ev1[c]));
            if (c < 7) chk($sformatf("t1_ready_c%0d", c), 32'(rr1[c]), 32'(er1[c]));
            if (rv1[c]) begin
                chk($sformatf("t1_data_b%0d", k), 32'(rd1[c]), 32'(9'h011 + 9'(k)));
                chk($sformatf("t1_id_b%0d", k), 32'(ri1[c]), 0);
                k++;
            end
        end
        chk("t1_beats", 32'(k), 5);

        // ---------------- Test 2: all four sources requesting continuously, 32 beats
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 1000;
        drive();
        #1;
        for (int c = 0; c < 200 && bcyc.size() < 32; c++) begin
            if (dst_vaild) begin
                bcyc.push_back(c);
                bid.push_back(int'(dst_src_id));
                bdat.push_back(dst_data);
            end
            run_cycle();
        end
        chk("t2_beats", 32'(bcyc.size()), 32);
        for (int b = 0; b < bcyc.size(); b++) begin
            chk($sformatf("t2_id_b%0d", b), 32'(bid[b]), 32'((b / 4) % 4));
            chk($sformatf("t2_data_b%0d", b), 32'(bdat[b]),
                32'({2'((b / 4) % 4), 7'((b / 16) * 4 + (b % 4))}));
            if (b > 0) chk($sformatf("t2_gap_b%0d", b), 32'(bcyc[b] - bcyc[b-1]),
                           32'((b % 4 == 0) ? 2 : 1));
        end

        // ---------------- Test 3: source 2 with a 5-cycle destination stall mid-burst
        do_reset();
        rem[2] = 4;
        drive();
        #1;
        beats      = 0;
        stall_done = 1'b0;
        for (int c = 0; c < 60 && beats < 4; c++) begin
            if (beats == 2 && !stall_done && dst_vaild) begin
                dst_ready = 1'b0;
                #1;
                for (int s = 0; s < 5; s++) begin
                    chk("t3_stall_vaild", 32'(dst_vaild),    1);
                    chk("t3_stall_data",  32'(dst_data),     32'({2'd2, 7'd2}));
                    chk("t3_stall_ready", 32'(src_ready[2]), 0);
                    chk("t3_stall_grant", 32'(grant),        32'(4'b0100));
                    run_cycle();
                end
                dst_ready  = 1'b1;
                stall_done = 1'b1;
                #1;
            end
            if (dst_vaild && dst_ready) begin
                chk("t3_id",   32'(dst_src_id), 2);
                chk("t3_data", 32'(dst_data),   32'({2'd2, 7'(beats)}));
                if (beats < 3) chk("t3_grant_held", 32'(grant), 32'(4'b0100));
                beats++;
            end
            run_cycle();
        end
        chk("t3_stalled", 32'(stall_done), 1);
        chk("t3_beats",   32'(beats),      4);

        // ---------------- Test 4: source 1 drops after 2 beats while 0 and 3 are waiting
        do_reset();
        rem[1] = 2;
        drive();
        n = 0;
        while (grant != 4'b0010 && n < 10) begin
            run_cycle();
            n++;
        end
        chk("t4_first_grant", 32'(grant), 32'(4'b0010));
        rem[0] = 1000;
        rem[3] = 1000;
        drive();
        #1;
        gq.push_back(grant);
        prev = grant;
        for (int c = 0; c < 60 && (gq.size() < 5 || iq.size() < 7); c++) begin
            if (dst_vaild && dst_ready) iq.push_back(int'(dst_src_id));
            run_cycle();
            if (grant != prev) begin
                gq.push_back(grant);
                prev = grant;
            end
        end
        chk("t4_grant_count", 32'(gq.size() >= 5), 1);
        chk("t4_beat_count",  32'(iq.size() >= 7), 1);
        for (int b = 0; b < 5; b++)
            if (b < gq.size()) chk($sformatf("t4_grant_%0d", b), 32'(gq[b]), 32'(eg4[b]));
        for (int b = 0; b < 7; b++)
            if (b < iq.size()) chk($sformatf("t4_id_%0d", b), 32'(iq[b]), 32'(ei4[b]));

        // ---------------- Test 5: reset pulse mid-burst with the output register full
        for (int i = 0; i < 4; i++) rem[i] = 1000;
        drive();
        #1;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (dst_vaild && dst_src_id == 2'd2 && grant == 4'b0100) found = 1'b1;
            else run_cycle();
        end
        chk("t5_midburst_found", 32'(found), 1);
        s_rst = 1'b1;
        run_cycle();
        s_rst = 1'b0;
        chk("t5_idle",       32'(idle),       1);
        chk("t5_grant",      32'(grant),      0);
        chk("t5_src_ready",  32'(src_ready),  0);
        chk("t5_dst_vaild",  32'(dst_vaild),  0);
        chk("t5_dst_data",   32'(dst_data),   0);
        chk("t5_dst_src_id", 32'(dst_src_id), 0);
        n = 0;
        while (grant == 4'b0 && n < 10) begin
            run_cycle();
            n++;
        end
        chk("t5_regrant", 32'(grant), 32'(4'b0001));
        n = 0;
        while (!dst_vaild && n < 10) begin
            run_cycle();
            n++;
        end
        chk("t5_first_vaild", 32'(dst_vaild),  1);
        chk("t5_first_id",    32'(dst_src_id), 0);

        // ---------------- Test 6: random soak with per-source scoreboard
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            recv[i] = 0;
            wt[i]   = 0;
            src_data[i*9 +: 9] = {2'(i), 7'd0};
        end
        src_vaild = '0;
        for (int c = 0; c < 300; c++) soak_cycle(1'b1, 1'b1);
        for (int c = 0; c < 60; c++)  soak_cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("soak_count_src%0d", i), 32'(recv[i]), 32'(sent[i]));
            chk($sformatf("soak_active_src%0d", i), 32'(sent[i] > 0), 1);
        end
        chk("soak_end_idle", 32'(idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
